// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 3-bit operation encoding and the LEGv8 opcodes
// that map onto it, so the ALU and its issue stage stay in agreement.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_SUB = 3'b001,
        ALU_ADD = 3'b010,
        ALU_DIV = 3'b011,
        ALU_MUL = 3'b100
    } alu_op_t;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_MUL  = 11'h4D8;
    localparam logic [10:0] OPC_SDIV = 11'h4D6;
    localparam logic [10:0] OPC_AND  = 11'h450;

    // Immediate forms only fix opcode[10:1]; bit 0 belongs to the immediate field.
    localparam logic [9:0] OPC_ADDI_HI = 10'h244;
    localparam logic [9:0] OPC_SUBI_HI = 10'h344;

    function automatic logic opc_imm_match(input logic [10:0] opcode, input logic [9:0] pattern);
        return (opcode[10:1] == pattern);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational LEGv8 opcode decoder: opcode -> ALU operation, immediate select
// and illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [10:0] opcode,
    output alu_op_t     alu_operation,
    output logic        use_imm,
    output logic        illegal
);

    // Full-opcode register forms first, then the 10-bit immediate forms.
    always_comb begin
        alu_operation = ALU_AND;
        use_imm       = 1'b0;
        illegal       = 1'b0;
        case (opcode)
            OPC_ADD:  alu_operation = ALU_ADD;
            OPC_SUB:  alu_operation = ALU_SUB;
            OPC_MUL:  alu_operation = ALU_MUL;
            OPC_SDIV: alu_operation = ALU_DIV;
            OPC_AND:  alu_operation = ALU_AND;
            default: begin
                if (opc_imm_match(opcode, OPC_ADDI_HI)) begin
                    alu_operation = ALU_ADD;
                    use_imm       = 1'b1;
                end else if (opc_imm_match(opcode, OPC_SUBI_HI)) begin
                    alu_operation = ALU_SUB;
                    use_imm       = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the 64-bit ALU: decode, operand select and a
// main+skid register pair behind valid/ready. Optional forwarding: ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       opcode,
    input  logic [DATA_W-1:0] rn_data,
    input  logic [DATA_W-1:0] rm_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [REG_W-1:0]  rn_idx,
    input  logic [REG_W-1:0]  rm_idx,
    input  logic [REG_W-1:0]  rd_idx,
`ifdef ALU_ISSUE_FWD_EN
    input  logic              ex_fwd_valid,
    input  logic [REG_W-1:0]  ex_fwd_rd,
    input  logic [DATA_W-1:0] ex_fwd_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_in,
    output logic [DATA_W-1:0] b_in,
    output logic [2:0]        alu_operation,
    output logic [REG_W-1:0]  rd_out,
    output logic              illegal_op
);

    localparam logic [REG_W-1:0] XZR = {REG_W{1'b1}};

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
        logic [REG_W-1:0]  rd;
        logic              illegal;
    } issue_entry_t;

    localparam issue_entry_t ENTRY_RESET = '{a: '0, b: '0, op: 3'b000, rd: '0, illegal: 1'b0};

    alu_op_t      dec_op_s;
    logic         dec_use_imm_s;
    logic         dec_illegal_s;
    logic [DATA_W-1:0] rn_val_s;
    logic [DATA_W-1:0] rm_val_s;
    issue_entry_t new_entry_s;

    issue_entry_t main_r, main_s;
    issue_entry_t skid_r, skid_s;
    logic         main_valid_r, main_valid_s;
    logic         skid_valid_r, skid_valid_s;
    logic         in_ready_r;
    logic         accept_s;
    logic         issue_s;

    alu_op_decode u_decode (
        .opcode        (opcode),
        .alu_operation (dec_op_s),
        .use_imm       (dec_use_imm_s),
        .illegal       (dec_illegal_s)
    );

`ifdef ALU_ISSUE_FWD_EN
    // Forward the in-flight EX result over stale register-file data; XZR is never forwarded.
    always_comb begin
        rn_val_s = rn_data;
        rm_val_s = rm_data;
        if (ex_fwd_valid && (ex_fwd_rd == rn_idx) && (rn_idx != XZR)) begin
            rn_val_s = ex_fwd_data;
        end else begin
            rn_val_s = rn_data;
        end
        if (ex_fwd_valid && (ex_fwd_rd == rm_idx) && (rm_idx != XZR)) begin
            rm_val_s = ex_fwd_data;
        end else begin
            rm_val_s = rm_data;
        end
    end
`else
    logic unused_idx_s;
    assign unused_idx_s = ^{rn_idx, rm_idx};
    assign rn_val_s     = rn_data;
    assign rm_val_s     = rm_data;
`endif

    // Build the entry captured on accept; illegal ops issue as a zeroed op to XZR.
    always_comb begin
        new_entry_s = ENTRY_RESET;
        if (dec_illegal_s) begin
            new_entry_s.a       = '0;
            new_entry_s.b       = '0;
            new_entry_s.op      = ALU_AND;
            new_entry_s.rd      = XZR;
            new_entry_s.illegal = 1'b1;
        end else begin
            new_entry_s.a       = rn_val_s;
            new_entry_s.b       = dec_use_imm_s ? imm : rm_val_s;
            new_entry_s.op      = dec_op_s;
            new_entry_s.rd      = rd_idx;
            new_entry_s.illegal = 1'b0;
        end
    end

    assign accept_s = in_valid && in_ready_r && !flush;
    assign issue_s  = main_valid_r && out_ready;

    // Main/skid next state; flush wins, skid refills main before new data is taken.
    always_comb begin
        main_s       = main_r;
        skid_s       = skid_r;
        main_valid_s = main_valid_r;
        skid_valid_s = skid_valid_r;
        if (flush) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (issue_s && skid_valid_r) begin
            main_s       = skid_r;
            main_valid_s = 1'b1;
            skid_valid_s = 1'b0;
        end else if (issue_s) begin
            if (accept_s) begin
                main_s       = new_entry_s;
                main_valid_s = 1'b1;
            end else begin
                main_valid_s = 1'b0;
            end
        end else if (accept_s) begin
            if (main_valid_r) begin
                skid_s       = new_entry_s;
                skid_valid_s = 1'b1;
            end else begin
                main_s       = new_entry_s;
                main_valid_s = 1'b1;
            end
        end else begin
            main_valid_s = main_valid_r;
        end
    end

    // State registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_r       <= ENTRY_RESET;
            skid_r       <= ENTRY_RESET;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_r       <= main_s;
            skid_r       <= skid_s;
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= !skid_valid_s;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = main_valid_r;
    assign a_in          = main_r.a;
    assign b_in          = main_r.b;
    assign alu_operation = main_r.op;
    assign rd_out        = main_r.rd;
    assign illegal_op    = main_r.illegal;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue stage sitting directly upstream of the 64-bit ALU. It decodes the LEGv8 opcode into the ALU's 3-bit `alu_operation` and selects operands (register or sign-extended immediate). It registers the result behind a valid/ready handshake with a 2-entry skid buffer, so a stalled execute stage never drops an instruction. It also supports flush and, optionally, EX-result forwarding.

## Interface
- DATA_W, 64, operand width
- REG_W, 5, register index width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; kills all held and incoming instructions
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept; registered
- opcode  in  11  instruction[31:21]
- rn_data, rm_data  in  DATA_W  register-file read data
- imm  in  DATA_W  sign-extended immediate
- rn_idx, rm_idx, rd_idx  in  REG_W  register indices
- out_valid  out  1  a_in/b_in/alu_operation valid for the ALU
- out_ready  in  1  execute stage consumes this cycle
- a_in, b_in  out  DATA_W  ALU operands
- alu_operation  out  3  ALU op code
- rd_out  out  REG_W  destination index
- illegal_op  out  1  held instruction did not decode

## Operation
- Decode uses opcode bits [10:0]. Any match not listed is illegal.
  - 0x458 ADD → 010, b=rm
  - 0x658 SUB → 001, b=rm
  - 0x4D8 MUL → 100, b=rm
  - 0x4D6 SDIV → 011, b=rm
  - 0x450 AND → 000, b=rm
  - opcode[10:1]=0x244 ADDI → 010, b=imm
  - opcode[10:1]=0x344 SUBI → 001, b=imm
- a_in is always rn_data.
- Illegal instructions are still issued, with illegal_op=1, alu_operation=000, a_in=b_in=0, and rd_out=31.
- Accept occurs when in_valid && in_ready. Issue occurs when out_valid && out_ready.
- There are two entries: main, which drives the outputs, and skid.
  - If the stage accepts while main is full and no issue happens that cycle, the instruction goes to skid.
  - When main issues and skid is full, skid moves to main.
- Output order is strictly the acceptance order.
- in_ready is 1 exactly when skid is empty.
- flush clears both valid bits. An instruction presented in the same cycle as flush is dropped, even if in_ready=1.

## Timing
- Reset values: out_valid=0, in_ready=1, a_in=b_in=0, alu_operation=000, rd_out=0, illegal_op=0.
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N, i.e. out_valid=1 in cycle N+1.
- Throughput is 1 instruction per cycle while out_ready=1.
- Outputs hold stable while out_valid && !out_ready.
- Simultaneous accept and issue with skid empty: the new instruction replaces main, and skid stays empty.
- Skid full plus issue: skid moves to main, and in_ready=1 next cycle. An accept in that same cycle is impossible because in_ready=0.
- flush has priority over accept and issue. After flush: out_valid=0 and in_ready=1 next cycle.
- Reset asserted mid-operation clears everything immediately, without waiting for clk.

## Configuration
- ALU_ISSUE_FWD_EN adds the ports ex_fwd_valid (1), ex_fwd_rd (REG_W) and ex_fwd_data (DATA_W).
- When defined, at accept time:
  - If ex_fwd_valid and ex_fwd_rd==rn_idx and rn_idx!=31, then a_in captures ex_fwd_data.
  - Likewise for rm_idx/b_in, for register-form ops only.
  - Index 31 (XZR) is never forwarded.
- When undefined, these ports are absent and operands come from rn_data/rm_data only.

## Structure
- Shared package alu_pkg holds the ALU op constants (ALU_AND=000, ALU_SUB=001, ALU_ADD=010, ALU_DIV=011, ALU_MUL=100) and the LEGv8 opcode constants listed above, so the ALU and this stage agree.
- One sub-module, alu_op_decode, is purely combinational: opcode → {alu_operation, use_imm, illegal}.
- The skid/main registers live in the top module.

## Test plan
- Reset then ADD (0x458), rn=5, rm=6, out_ready=1 → next cycle out_valid=1, a_in=5, b_in=6, alu_operation=010; the ALU result is 11.
- ADDI (0x488), rn=40, imm=8, then SDIV (0x4D6), rn=40, rm=8, back-to-back → two consecutive issues: (40,8,010) then (40,8,011).
- Hold out_ready=0 and send MUL 8×7 then SUB 10−7 → in_ready=0 after the second accept and outputs hold MUL. Raise out_ready → MUL, then SUB (001), in order, and in_ready returns to 1.
- Illegal opcode 0x7FF → issued with illegal_op=1, alu_operation=000, operands 0, rd_out=31.
- With skid full, assert flush together with in_valid → next cycle out_valid=0 and in_ready=1, and no instruction is ever issued.
- With ALU_ISSUE_FWD_EN defined: ex_fwd_rd=3, data=99; ADD with rn_idx=3 → a_in=99. Repeat with rn_idx=31 → a_in=rn_data.
